// File: rtl/test_host_monitor_if.sv
// Data-memory port bundle between the core's MEM stage and the tohost monitor.
//   master: core side, drives req/we/addr/wdata/wstrb and sees ack/rdata/hit.
//   slave : monitor side, drives ack/rdata/hit.
interface test_host_monitor_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;
  logic        hit;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata, hit);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata, hit);
endinterface

// File: rtl/test_host_monitor.sv
// Memory-mapped "tohost" responder for riscv-tests. Latches the end-of-test
// verdict, counts cycles since reset release and forces a failing verdict
// when the watchdog expires.
//
// Optional feature macro: TEST_HOST_CONSOLE_EN (console byte FIFO at
// CONSOLE_ADDR). When it is not defined the console address is not decoded,
// char_valid/char_data are tied low and char_ready is ignored.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   bus        slave side of the data-memory port (req/we/addr/wdata/wstrb in,
//              ack/rdata/hit out; hit is combinational from addr)
//   done       verdict reached (tohost or watchdog), sticky
//   pass       meaningful while done; 1 only for tohost value 1
//   timeout    done was forced by the watchdog, sticky
//   test_num   tohost[31:1] of a failing write, else 0
//   cycles     cycles since reset release, frozen once done
//   char_valid console byte available
//   char_data  console byte at FIFO head
//   char_ready consumer takes the byte when char_valid & char_ready
//
// state | meaning
// IDLE  | waiting for req on a mapped address; the access is performed on the accept edge
// RESP  | ack high for this single cycle; no new access is accepted here
module test_host_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] CYCLE_ADDR     = 32'h0000_1004,
  parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_1008,
  parameter int unsigned TIMEOUT_CYCLES = 6000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  test_host_monitor_if.slave bus,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [30:0]        test_num,
  output logic [31:0]        cycles,
  output logic               char_valid,
  output logic [7:0]         char_data,
  input  logic               char_ready
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        accept;
  logic        stall;
  logic        sel_tohost, sel_cycle, sel_console;
  logic        wr_tohost, verdict_set, watchdog_set;
  logic [31:0] tohost_q;
  logic [31:0] console_rd;

  assign sel_tohost = (bus.addr == TOHOST_ADDR);
  assign sel_cycle  = (bus.addr == CYCLE_ADDR);
  assign bus.hit    = sel_tohost | sel_cycle | sel_console;
  assign bus.ack    = (state_q == RESP);

`ifdef TEST_HOST_CONSOLE_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, push, pop;

  assign sel_console = (bus.addr == CONSOLE_ADDR);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign char_valid  = (wr_ptr != rd_ptr);
  assign char_data   = fifo_mem[rd_ptr[AW-1:0]];
  assign pop         = char_valid && char_ready;
  assign push        = accept && bus.we && sel_console && bus.wstrb[0];
  // A pop in the same cycle frees the slot, so a full FIFO only stalls without one.
  assign stall       = sel_console && bus.we && bus.wstrb[0] && fifo_full && !pop;
  assign console_rd  = {31'b0, fifo_full};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.wdata[7:0];
  end
`else
  logic unused_cfg;

  assign sel_console = 1'b0;
  assign stall       = 1'b0;
  assign char_valid  = 1'b0;
  assign char_data   = 8'h00;
  assign console_rd  = 32'h0;
  assign unused_cfg  = ^{char_ready, CONSOLE_ADDR, 32'(FIFO_DEPTH)};
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req && bus.hit && !stall) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Only full-word tohost writes count; a verdict write beats a same-cycle watchdog expiry.
  assign wr_tohost    = accept && bus.we && sel_tohost && (bus.wstrb == 4'hF);
  assign verdict_set  = wr_tohost && !done && bus.wdata[0];
  assign watchdog_set = (TIMEOUT_CYCLES != 0) && !done && !verdict_set && (cycles == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rdata <= '0;
      tohost_q  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      test_num  <= '0;
      cycles    <= '0;
    end else begin
      if (accept && !bus.we) begin
        if (sel_tohost)     bus.rdata <= tohost_q;
        else if (sel_cycle) bus.rdata <= cycles;
        else                bus.rdata <= console_rd;
      end
      if (wr_tohost) tohost_q <= bus.wdata;
      if (verdict_set) begin
        done     <= 1'b1;
        pass     <= (bus.wdata == 32'd1);
        test_num <= (bus.wdata == 32'd1) ? 31'd0 : bus.wdata[31:1];
      end else if (watchdog_set) begin
        done     <= 1'b1;
        timeout  <= 1'b1;
        pass     <= 1'b0;
        test_num <= '0;
      end
      // The counter holds on the edge that sets done, so it reads the final cycle index.
      if (!done && !verdict_set && !watchdog_set && (cycles != 32'hFFFF_FFFF))
        cycles <= cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_test_host_monitor.sv
module tb_test_host_monitor;
  localparam int unsigned TB_TIMEOUT = 100;
  localparam logic [31:0] A_TOHOST  = 32'h0000_1000;
  localparam logic [31:0] A_CYCLE   = 32'h0000_1004;
  localparam logic [31:0] A_CONSOLE = 32'h0000_1008;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        char_ready = 1'b0;
  logic        done, pass, timeout, char_valid;
  logic [30:0] test_num;
  logic [31:0] cycles;
  logic [7:0]  char_data;

  test_host_monitor_if bus_i ();

  test_host_monitor #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_i),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .test_num   (test_num),
    .cycles     (cycles),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model of the verdict registers
  logic        m_done, m_pass, m_timeout;
  logic [30:0] m_test_num;
  logic [31:0] m_cycles, m_tohost;
  logic        pend_wr = 1'b0;
  logic [31:0] pend_wd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_done = 0; m_pass = 0; m_timeout = 0; m_test_num = 0;
    m_cycles = 0; m_tohost = 0; pend_wr = 0;
  endtask

  task automatic model_edge();
    bit verdict;
    verdict = pend_wr && !m_done && pend_wd[0];
    if (pend_wr) m_tohost = pend_wd;
    if (verdict) begin
      m_done     = 1;
      m_pass     = (pend_wd == 32'd1);
      m_test_num = (pend_wd == 32'd1) ? 31'd0 : pend_wd[31:1];
    end else if (!m_done && m_cycles == TB_TIMEOUT - 1) begin
      m_done = 1; m_timeout = 1; m_pass = 0; m_test_num = 0;
    end else if (!m_done && m_cycles != 32'hFFFF_FFFF) begin
      m_cycles = m_cycles + 1;
    end
    pend_wr = 0;
  endtask

  task automatic check_state();
    chk("st_done", done, m_done);
    chk("st_pass", pass, m_pass);
    chk("st_timeout", timeout, m_timeout);
    chk("st_test_num", test_num, m_test_num);
    chk("st_cycles", cycles, m_cycles);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    bus_i.req = 0; bus_i.we = 0; bus_i.addr = 0; bus_i.wdata = 0; bus_i.wstrb = 0;
    char_ready = 0;
    model_reset();
    #1;
    chk("rst_ack", bus_i.ack, 0);
    chk("rst_rdata", bus_i.rdata, 0);
    check_state();
    chk("rst_char_valid", char_valid, 0);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string tag);
    logic        exp_hit;
    logic [31:0] exp_rd;
    exp_hit = (a == A_TOHOST) || (a == A_CYCLE);
`ifdef TEST_HOST_CONSOLE_EN
    if (a == A_CONSOLE) exp_hit = 1'b1;
`endif
    bus_i.req = 1; bus_i.we = w; bus_i.addr = a; bus_i.wdata = d; bus_i.wstrb = s;
    #1;
    chk({tag, "_hit"}, bus_i.hit, exp_hit);
    if (exp_hit) begin
      exp_rd  = (a == A_TOHOST) ? m_tohost : (a == A_CYCLE) ? m_cycles : 32'd0;
      pend_wr = w && (a == A_TOHOST) && (s == 4'hF);
      pend_wd = d;
      cyc();
      chk({tag, "_ack"}, bus_i.ack, 1);
      if (!w && a != A_CONSOLE) chk({tag, "_rdata"}, bus_i.rdata, exp_rd);
      bus_i.req = 0;
      cyc();
      chk({tag, "_ack_low"}, bus_i.ack, 0);
    end else begin
      repeat (3) begin
        cyc();
        chk({tag, "_noack"}, bus_i.ack, 0);
      end
      bus_i.req = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          n;
    int          nops;
    logic [31:0] d;

    bus_i.req = 0; bus_i.we = 0; bus_i.addr = 0; bus_i.wdata = 0; bus_i.wstrb = 0;
    model_reset();

    // passing tohost write
    do_reset();
    access(1, A_TOHOST, 32'd1, 4'hF, "t1_pass");
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_test_num", test_num, 0);

    // failing write, later passing write cannot overturn it
    do_reset();
    access(1, A_TOHOST, 32'h7, 4'hF, "t2_fail");
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    chk("t2_test_num", test_num, 3);
    access(1, A_TOHOST, 32'd1, 4'hF, "t2_late");
    chk("t2_sticky_pass", pass, 0);
    chk("t2_sticky_num", test_num, 3);
    access(0, A_TOHOST, 32'd0, 4'h0, "t2_rd");
    chk("t2_rd_stored", bus_i.rdata, 32'd1);

    // partial write ignored, even value stored without verdict
    do_reset();
    access(1, A_TOHOST, 32'd1, 4'h7, "pw");
    chk("pw_no_done", done, 0);
    access(1, A_TOHOST, 32'h10, 4'hF, "even");
    chk("even_no_done", done, 0);
    access(0, A_TOHOST, 32'd0, 4'h0, "even_rd");
    chk("even_rd_val", bus_i.rdata, 32'h10);

    // watchdog
    do_reset();
    n = 0;
    while (!done && n < 200) begin
      cyc();
      n++;
    end
    chk("to_done", done, 1);
    chk("to_timeout", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_cycles", cycles, TB_TIMEOUT - 1);
    repeat (10) cyc();
    chk("to_frozen", cycles, TB_TIMEOUT - 1);

    // cycle read after 50 cycles, unmapped access
    do_reset();
    repeat (50) cyc();
    access(0, A_CYCLE, 32'd0, 4'h0, "cyc_rd");
    chk("cyc50", bus_i.rdata, 32'd50);
    access(1, 32'h0000_2000, 32'd1, 4'hF, "miss");
    chk("miss_no_done", done, 0);

    // req held through the ack edge is not re-accepted in the ack cycle
    do_reset();
    bus_i.req = 1; bus_i.we = 0; bus_i.addr = A_TOHOST; bus_i.wstrb = 0;
    cyc();
    chk("b2b_ack1", bus_i.ack, 1);
    cyc();
    chk("b2b_gap", bus_i.ack, 0);
    cyc();
    chk("b2b_ack2", bus_i.ack, 1);
    bus_i.req = 0;
    cyc();
    chk("b2b_end", bus_i.ack, 0);

    // async reset in the response cycle
    do_reset();
    bus_i.req = 1; bus_i.we = 1; bus_i.addr = A_TOHOST; bus_i.wdata = 32'd1; bus_i.wstrb = 4'hF;
    pend_wr = 1; pend_wd = 32'd1;
    cyc();
    chk("ar_ack_before", bus_i.ack, 1);
    #2;
    rst = 0;
    #1;
    chk("ar_ack", bus_i.ack, 0);
    chk("ar_done", done, 0);
    chk("ar_pass", pass, 0);
    chk("ar_cycles", cycles, 0);
    chk("ar_rdata", bus_i.rdata, 0);
    bus_i.req = 0;
    do_reset();

`ifdef TEST_HOST_CONSOLE_EN
    for (int i = 0; i < 4; i++) access(1, A_CONSOLE, 32'h41 + i, 4'h1, "con_push");
    chk("con_valid", char_valid, 1);
    chk("con_head", char_data, 8'h41);
    bus_i.req = 1; bus_i.we = 1; bus_i.addr = A_CONSOLE; bus_i.wdata = 32'h45; bus_i.wstrb = 4'h1;
    repeat (3) begin
      cyc();
      chk("con_stall", bus_i.ack, 0);
    end
    char_ready = 1;
    cyc();
    char_ready = 0;
    chk("con_pop_ack", bus_i.ack, 1);
    chk("con_next_head", char_data, 8'h42);
    bus_i.req = 0;
    cyc();
    chk("con_ack_low", bus_i.ack, 0);
`else
    char_ready = 1;
    access(1, A_CONSOLE, 32'h41, 4'h1, "con_off");
    chk("con_off_valid", char_valid, 0);
    chk("con_off_data", char_data, 0);
    char_ready = 0;
`endif

    // randomized traffic against the model
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      nops = $urandom_range(1, 6);
      for (int k = 0; k < nops; k++) begin
        case ($urandom_range(0, 5))
          0: begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d = 32'd1;
            access(1, A_TOHOST, d, 4'hF, "rnd_wr");
          end
          1: access(1, A_TOHOST, $urandom, 4'($urandom_range(0, 14)), "rnd_pwr");
          2: access(0, A_TOHOST, 32'd0, 4'h0, "rnd_rd_th");
          3: access(0, A_CYCLE, 32'd0, 4'h0, "rnd_rd_cyc");
          4: access(1, A_CYCLE, $urandom, 4'hF, "rnd_wr_cyc");
          default: access(1'($urandom_range(0, 1)), 32'h2000 + ($urandom_range(0, 255) << 2),
                          $urandom, 4'hF, "rnd_miss");
        endcase
        repeat ($urandom_range(0, 25)) cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
